// File: rtl/adpcm_code_packer.sv
// Packs 4-bit ADPCM codes (first code in the low nibble) into words and queues them in a FWFT FIFO.
// Optional ADPCM_PACK_STATS_EN adds a saturating drop_count output.
module adpcm_code_packer #(
    parameter int unsigned NIBBLES_PER_WORD = 2,
    parameter int unsigned FIFO_DEPTH       = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [3:0]                    code,
    input  logic                          code_valid,
    input  logic                          flush,
    output logic [4*NIBBLES_PER_WORD-1:0] out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
`ifdef ADPCM_PACK_STATS_EN
    ,
    output logic [15:0]                   drop_count
`endif
);

    localparam int unsigned WORD_W = 4 * NIBBLES_PER_WORD;
    localparam int unsigned CNT_W  = $clog2(NIBBLES_PER_WORD);
    localparam int unsigned IDX_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned PTR_W  = IDX_W + 1;
    localparam logic [CNT_W-1:0] LastNib = CNT_W'(NIBBLES_PER_WORD - 1);

    typedef enum logic [0:0] {StFill, StPad} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   nib_cnt_q, nib_cnt_d;
    logic [WORD_W-1:0]  asm_q, asm_d;
    logic [WORD_W-1:0]  word_next;
    logic               complete, has_data, push;

    logic [WORD_W-1:0]  mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   level, level_d;
    logic [WORD_W-1:0]  out_data_q, out_data_d;
    logic               full, pop, wr_en, drop, overflow_q;

    // Packer: word_next is the assembly register with this cycle's code merged in.
    always_comb begin
        word_next = asm_q;
        for (int i = 0; i < int'(NIBBLES_PER_WORD); i++) begin
            if (code_valid && nib_cnt_q == CNT_W'(i)) begin
                word_next[4*i +: 4] = code;
            end
        end
        complete = code_valid && (nib_cnt_q == LastNib);
        has_data = code_valid || (nib_cnt_q != '0);
        push     = complete || (flush && has_data);

        // PAD only follows a flush that coincided with a completing code; the partial word is
        // then empty, so its padding is a no-op and incoming codes are taken as in FILL.
        state_d = state_q;
        unique case (state_q)
            StFill:  if (flush && complete) state_d = StPad;
            StPad:   state_d = StFill;
            default: state_d = StFill;
        endcase

        asm_d     = asm_q;
        nib_cnt_d = nib_cnt_q;
        if (push) begin
            asm_d     = '0;
            nib_cnt_d = '0;
        end else if (code_valid) begin
            asm_d     = word_next;
            nib_cnt_d = nib_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StFill;
            nib_cnt_q <= '0;
            asm_q     <= '0;
        end else begin
            state_q   <= state_d;
            nib_cnt_q <= nib_cnt_d;
            asm_q     <= asm_d;
        end
    end

    // FIFO: a pop frees a slot before a same-cycle push is judged against full.
    always_comb begin
        level    = wr_ptr_q - rd_ptr_q;
        full     = (level == PTR_W'(FIFO_DEPTH));
        pop      = (level != '0) && out_ready;
        wr_en    = push && (!full || pop);
        drop     = push && full && !pop;
        wr_ptr_d = wr_ptr_q + PTR_W'(wr_en);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        level_d  = wr_ptr_d - rd_ptr_d;

        // Next head: hold when going empty, bypass the word being written if it becomes head.
        out_data_d = out_data_q;
        if (level_d != '0) begin
            if (wr_en && rd_ptr_d[IDX_W-1:0] == wr_ptr_q[IDX_W-1:0]) begin
                out_data_d = word_next;
            end else begin
                out_data_d = mem[rd_ptr_d[IDX_W-1:0]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q[IDX_W-1:0]] <= word_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            out_data_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            out_data_q <= out_data_d;
            if (drop) overflow_q <= 1'b1;
        end
    end

    assign out_data   = out_data_q;
    assign out_valid  = (level != '0);
    assign fifo_level = level;
    assign overflow   = overflow_q;

`ifdef ADPCM_PACK_STATS_EN
    logic [15:0] drop_count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_count_q <= '0;
        end else if (drop && drop_count_q != 16'hFFFF) begin
            drop_count_q <= drop_count_q + 16'd1;
        end
    end

    assign drop_count = drop_count_q;
`endif

endmodule

// File: tb/tb_adpcm_code_packer.sv
// Self-checking bench for adpcm_code_packer (N=2, depth 8): vector table plus multi-cycle scenarios.
module tb_adpcm_code_packer;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] code;
    logic       code_valid;
    logic       flush;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       overflow;
    logic [3:0] fifo_level;
`ifdef ADPCM_PACK_STATS_EN
    logic [15:0] drop_count;
`endif

    int checks = 0;
    int errors = 0;
    logic [7:0] sb[$];

    typedef struct {
        logic [3:0] code;
        logic       valid;
        logic       flush;
        logic       push;
        logic [7:0] word;
    } vec_t;

    vec_t tbl[11];

    always #5 clk = ~clk;

    adpcm_code_packer #(
        .NIBBLES_PER_WORD(2),
        .FIFO_DEPTH      (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .code      (code),
        .code_valid(code_valid),
        .flush     (flush),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overflow  (overflow),
        .fifo_level(fifo_level)
`ifdef ADPCM_PACK_STATS_EN
        ,
        .drop_count(drop_count)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every handshake must match the oldest expected word.
    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected actual=%0h required=none", out_data);
            end else begin
                check("sb_word", {24'd0, out_data}, {24'd0, sb.pop_front()});
            end
        end
    end

    task automatic cycle(input logic [3:0] c, input logic v, input logic f);
        code       = c;
        code_valid = v;
        flush      = f;
        @(posedge clk);
        #1;
        code_valid = 1'b0;
        flush      = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        while ((sb.size() != 0 || out_valid) && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_sb_empty", sb.size(), 0);
        check("drain_level", {28'd0, fifo_level}, 0);
    endtask

    // Fill all 8 slots with words 21,43,...,0F while out_ready is low.
    task automatic fill16();
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            cycle(4'(i + 1), 1'b1, 1'b0);
            if (i % 2 == 1) sb.push_back({4'(i + 1), 4'(i)});
        end
    endtask

    initial begin
        tbl[0]  = '{4'h3, 1'b1, 1'b0, 1'b0, 8'h00};
        tbl[1]  = '{4'hA, 1'b1, 1'b0, 1'b1, 8'hA3};
        tbl[2]  = '{4'h5, 1'b1, 1'b0, 1'b0, 8'h00};
        tbl[3]  = '{4'h0, 1'b0, 1'b1, 1'b1, 8'h05};
        tbl[4]  = '{4'h0, 1'b0, 1'b1, 1'b0, 8'h00};
        tbl[5]  = '{4'h7, 1'b1, 1'b1, 1'b1, 8'h07};
        tbl[6]  = '{4'h1, 1'b1, 1'b0, 1'b0, 8'h00};
        tbl[7]  = '{4'h2, 1'b1, 1'b1, 1'b1, 8'h21};
        tbl[8]  = '{4'h0, 1'b0, 1'b1, 1'b0, 8'h00};
        tbl[9]  = '{4'hB, 1'b1, 1'b0, 1'b0, 8'h00};
        tbl[10] = '{4'hC, 1'b1, 1'b0, 1'b1, 8'hCB};

        reset      = 1'b0;
        code       = 4'h0;
        code_valid = 1'b0;
        flush      = 1'b0;
        out_ready  = 1'b0;
        #1;
        check("rst_valid", {31'd0, out_valid}, 0);
        check("rst_level", {28'd0, fifo_level}, 0);
        check("rst_data", {24'd0, out_data}, 0);
        check("rst_overflow", {31'd0, overflow}, 0);
        #12 reset = 1'b1;
        @(posedge clk);
        #1;

        // Vector table with the consumer always ready: each pushed word is visible one cycle.
        out_ready = 1'b1;
        foreach (tbl[k]) begin
            cycle(tbl[k].code, tbl[k].valid, tbl[k].flush);
            if (tbl[k].push) sb.push_back(tbl[k].word);
            check($sformatf("vec%0d_valid", k), {31'd0, out_valid}, {31'd0, tbl[k].push});
            check($sformatf("vec%0d_level", k), {28'd0, fifo_level}, {31'd0, tbl[k].push});
        end
        drain();

        // Full FIFO, completing code coincides with a pop: accepted, level stays 8.
        fill16();
        check("full_level", {28'd0, fifo_level}, 8);
        check("full_overflow", {31'd0, overflow}, 0);
        check("full_head", {24'd0, out_data}, 8'h21);
        cycle(4'h3, 1'b1, 1'b0);
        out_ready = 1'b1;
        cycle(4'h4, 1'b1, 1'b0);
        sb.push_back(8'h43);
        check("pushpop_level", {28'd0, fifo_level}, 8);
        check("pushpop_overflow", {31'd0, overflow}, 0);
        drain();

        // Overflow: the 9th word is dropped, flag sticks, order is preserved.
        fill16();
        check("ovf_pre_level", {28'd0, fifo_level}, 8);
        check("ovf_pre_flag", {31'd0, overflow}, 0);
        cycle(4'h1, 1'b1, 1'b0);
        cycle(4'h2, 1'b1, 1'b0);
        check("ovf_flag", {31'd0, overflow}, 1);
        check("ovf_level", {28'd0, fifo_level}, 8);
        drain();
        check("ovf_sticky", {31'd0, overflow}, 1);

        // Asynchronous reset mid-word with three words queued.
        out_ready = 1'b0;
        for (int i = 1; i <= 6; i++) cycle(4'(i), 1'b1, 1'b0);
        cycle(4'h9, 1'b1, 1'b0);
        check("pre_rst_level", {28'd0, fifo_level}, 3);
        #2 reset = 1'b0;
        #1;
        check("arst_valid", {31'd0, out_valid}, 0);
        check("arst_level", {28'd0, fifo_level}, 0);
        check("arst_overflow", {31'd0, overflow}, 0);
        #3 reset = 1'b1;
        @(posedge clk);
        #1;
        cycle(4'h7, 1'b1, 1'b0);
        cycle(4'h8, 1'b1, 1'b0);
        sb.push_back(8'h87);
        check("post_rst_level", {28'd0, fifo_level}, 1);
        check("post_rst_data", {24'd0, out_data}, 8'h87);
        drain();

`ifdef ADPCM_PACK_STATS_EN
        reset = 1'b0;
        #2 reset = 1'b1;
        @(posedge clk);
        #1;
        fill16();
        for (int i = 0; i < 6; i++) cycle(4'(i), 1'b1, 1'b0);
        check("stats_drop_count", {16'd0, drop_count}, 3);
        check("stats_overflow", {31'd0, overflow}, 1);
        drain();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
